pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_DEPTH, default 3: advancing cycles needed after HALT enters ID/EX, before the pipeline is considered empty (legal range 1..15).
REQ-002 SHALL have port i_clock  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_start  in  1  level; leaves IDLE.
REQ-005 SHALL have port i_mode  in  1  0 = continuous, 1 = step; sampled only in IDLE.
REQ-006 SHALL have port i_step  in  1  step request; rising edge is significant.
REQ-007 SHALL have ports i_idex_memread (in, 1), i_idex_rt (in, 5), i_ifid_rs (in, 5) and i_ifid_rt (in, 5) for load-use detection.
REQ-008 SHALL have port i_halt_id  in  1  HALT decoded in ID stage.
REQ-009 SHALL have ports i_mem_req (in, 1), the MEM stage accessing data memory, and i_mem_ack (in, 1), data memory done.
REQ-010 SHALL have outputs o_pc_en, o_ifid_en, o_idex_en, o_exmem_en and o_memwb_en, each 1 bit: stage-register load enables.
REQ-011 SHALL have output o_idex_flush  out  1  loads a bubble (wb/mem controls zero) into ID/EX.
REQ-012 SHALL have outputs o_halted (out, 1) and o_state (out, 3): IDLE=0, RUN=1, STEP_WAIT=2, STEP_EXEC=3, DRAIN=4, HALTED=5.
REQ-013 SHALL have output o_cycles  out  32  count of advancing cycles.

Function
REQ-014 SHALL define freeze = i_mem_req & ~i_mem_ack; SHALL define loaduse = i_idex_memread & (i_idex_rt != 0) & (i_idex_rt == i_ifid_rs | i_idex_rt == i_ifid_rt).
REQ-015 SHALL define an advancing cycle as one in state RUN, STEP_EXEC or DRAIN with freeze = 0.
REQ-016 SHALL drive every enable and the flush to 0 in IDLE, STEP_WAIT and HALTED, and on any freeze cycle (freeze overrides everything).
REQ-017 SHALL, on an advancing cycle in RUN/STEP_EXEC with loaduse = 0, assert all five enables with o_idex_flush = 0.
REQ-018 SHALL, on an advancing cycle in RUN/STEP_EXEC with loaduse = 1, drive o_pc_en = o_ifid_en = 0, assert o_idex_flush, and assert o_idex_en, o_exmem_en and o_memwb_en.
REQ-019 SHALL ignore i_halt_id on loaduse or freeze cycles.
REQ-020 SHALL, on an advancing non-loaduse cycle in RUN/STEP_EXEC with i_halt_id = 1, enter DRAIN next cycle with the drain counter cleared.
REQ-021 SHALL, in DRAIN on each advancing cycle, drive o_pc_en = o_ifid_en = 0, assert o_idex_flush, assert the other enables, and increment the counter.
REQ-022 SHALL go DRAIN -> HALTED on the cycle after the counter reaches DRAIN_DEPTH.
REQ-023 SHALL make HALTED exit only via reset, with o_halted = 1 only in HALTED.
REQ-024 SHALL go IDLE -> RUN (i_mode = 0) or IDLE -> STEP_WAIT (i_mode = 1) on the clock edge where i_start = 1.
REQ-025 SHALL register i_step and take a step edge as i_step & ~step_q.
REQ-026 SHALL go STEP_WAIT -> STEP_EXEC on a step edge.
REQ-027 SHALL hold STEP_EXEC while freeze = 1, and otherwise perform exactly one advancing cycle (a loaduse bubble counts as the step), then return to STEP_WAIT or go to DRAIN per REQ-020.
REQ-028 SHALL ignore step edges outside STEP_WAIT.
REQ-029 SHALL have RUN persist until HALT.
REQ-030 SHALL increment o_cycles (mod 2^32, wraps) on each advancing cycle; it SHALL never decrement.
REQ-031 SHALL make enables combinational from the registered state and current inputs, with zero-cycle latency.

Reset
REQ-032 SHALL, while i_reset = 0, asynchronously force state IDLE, the drain counter 0, step_q 0 and o_cycles 0, so all enables, o_idex_flush and o_halted read 0.
REQ-033 SHALL, on reset asserted mid-RUN, mid-DRAIN or mid-freeze, take effect immediately without waiting for a clock edge; after release, remain in IDLE until i_start.

Verification
REQ-034 SHALL cover: i_mode = 0, start, 10 clean cycles -> all enables 1 each cycle, o_cycles = 10.
REQ-035 SHALL cover: RUN, i_idex_memread = 1, i_idex_rt = 5, i_ifid_rs = 5 for one cycle -> pc/ifid_en 0, flush 1, others 1; o_cycles still increments; the same with rt = 0 -> no stall.
REQ-036 SHALL cover: RUN, i_mem_req = 1 with ack low for 4 cycles -> all outputs 0, o_cycles frozen, state stays 1; ack then resumes.
REQ-037 SHALL cover: RUN, i_halt_id = 1 -> state 4 for 3 advancing cycles with flush 1, then state 5, o_halted = 1, enables 0 thereafter; repeat with a freeze inside DRAIN -> drain extended by the freeze length.
REQ-038 SHALL cover: i_mode = 1, hold i_step high for 5 cycles -> exactly one advancing cycle; three separate pulses -> o_cycles = 3.
REQ-039 SHALL cover: reset pulse mid-DRAIN, asynchronous to the clock -> outputs 0 and o_state = 0 before the next edge.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: run/step sequencing, load-use stalls, memory freeze,
// HALT drain and advancing-cycle counter for a five-stage pipeline.
module pipeline_ctrl #(
    parameter int unsigned DRAIN_DEPTH = 3
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_mode,
    input  logic        i_step,
    input  logic        i_idex_memread,
    input  logic [4:0]  i_idex_rt,
    input  logic [4:0]  i_ifid_rs,
    input  logic [4:0]  i_ifid_rt,
    input  logic        i_halt_id,
    input  logic        i_mem_req,
    input  logic        i_mem_ack,
    output logic        o_pc_en,
    output logic        o_ifid_en,
    output logic        o_idex_en,
    output logic        o_exmem_en,
    output logic        o_memwb_en,
    output logic        o_idex_flush,
    output logic        o_halted,
    output logic [2:0]  o_state,
    output logic [31:0] o_cycles
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CYC_W   = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP_WAIT = 3'd2,
        ST_STEP_EXEC = 3'd3,
        ST_DRAIN     = 3'd4,
        ST_HALTED    = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic               step_q, step_d;
    logic [CYC_W-1:0]   cycles_q, cycles_d;

    logic               freeze;
    logic               loaduse;
    logic               step_edge;
    logic               advancing;

    // Hazard and step-edge detection from current inputs.
    assign freeze    = i_mem_req & ~i_mem_ack;
    assign loaduse   = i_idex_memread & (i_idex_rt != 5'd0) &
                       ((i_idex_rt == i_ifid_rs) | (i_idex_rt == i_ifid_rt));
    assign step_edge = i_step & ~step_q;

    // Next-state, drain counter, cycle counter and stage enables.
    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        step_d       = i_step;
        advancing    = 1'b0;
        o_pc_en      = 1'b0;
        o_ifid_en    = 1'b0;
        o_idex_en    = 1'b0;
        o_exmem_en   = 1'b0;
        o_memwb_en   = 1'b0;
        o_idex_flush = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = i_mode ? ST_STEP_WAIT : ST_RUN;
                end
            end

            ST_RUN, ST_STEP_EXEC: begin
                if (!freeze) begin
                    advancing  = 1'b1;
                    o_idex_en  = 1'b1;
                    o_exmem_en = 1'b1;
                    o_memwb_en = 1'b1;
                    if (loaduse) begin
                        // Hold PC/IF-ID, inject a bubble behind the load.
                        o_idex_flush = 1'b1;
                        if (state_q == ST_STEP_EXEC) begin
                            state_d = ST_STEP_WAIT;
                        end
                    end else begin
                        o_pc_en   = 1'b1;
                        o_ifid_en = 1'b1;
                        if (i_halt_id) begin
                            state_d     = ST_DRAIN;
                            drain_cnt_d = '0;
                        end else if (state_q == ST_STEP_EXEC) begin
                            state_d = ST_STEP_WAIT;
                        end
                    end
                end
            end

            ST_STEP_WAIT: begin
                if (step_edge) begin
                    state_d = ST_STEP_EXEC;
                end
            end

            ST_DRAIN: begin
                if (!freeze) begin
                    // Stop fetch; push bubbles so older instructions retire.
                    advancing    = 1'b1;
                    o_idex_flush = 1'b1;
                    o_idex_en    = 1'b1;
                    o_exmem_en   = 1'b1;
                    o_memwb_en   = 1'b1;
                    drain_cnt_d  = drain_cnt_q + CNT_W'(1);
                    if (drain_cnt_q == CNT_W'(DRAIN_DEPTH - 1)) begin
                        state_d = ST_HALTED;
                    end
                end
            end

            ST_HALTED: begin
                state_d = ST_HALTED;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cycles_d = advancing ? (cycles_q + CYC_W'(1)) : cycles_q;
    end

    // State, drain counter, step history and cycle counter registers.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= ST_IDLE;
            drain_cnt_q <= '0;
            step_q      <= 1'b0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            step_q      <= step_d;
            cycles_q    <= cycles_d;
        end
    end

    assign o_state  = STATE_W'(state_q);
    assign o_halted = (state_q == ST_HALTED);
    assign o_cycles = cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: run, stall, freeze, drain, step, reset.
module tb_pipeline_ctrl;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_start, i_mode, i_step;
    logic        i_idex_memread;
    logic [4:0]  i_idex_rt, i_ifid_rs, i_ifid_rt;
    logic        i_halt_id, i_mem_req, i_mem_ack;
    logic        o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en;
    logic        o_idex_flush, o_halted;
    logic [2:0]  o_state;
    logic [31:0] o_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    // {pc, ifid, idex, exmem, memwb, flush}
    logic [5:0] en_vec;
    assign en_vec = {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en, o_idex_flush};

    localparam logic [5:0] EN_OFF   = 6'b000000;
    localparam logic [5:0] EN_CLEAN = 6'b111110;
    localparam logic [5:0] EN_BUB   = 6'b001111;

    pipeline_ctrl #(.DRAIN_DEPTH(3)) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_mode         (i_mode),
        .i_step         (i_step),
        .i_idex_memread (i_idex_memread),
        .i_idex_rt      (i_idex_rt),
        .i_ifid_rs      (i_ifid_rs),
        .i_ifid_rt      (i_ifid_rt),
        .i_halt_id      (i_halt_id),
        .i_mem_req      (i_mem_req),
        .i_mem_ack      (i_mem_ack),
        .o_pc_en        (o_pc_en),
        .o_ifid_en      (o_ifid_en),
        .o_idex_en      (o_idex_en),
        .o_exmem_en     (o_exmem_en),
        .o_memwb_en     (o_memwb_en),
        .o_idex_flush   (o_idex_flush),
        .o_halted       (o_halted),
        .o_state        (o_state),
        .o_cycles       (o_cycles)
    );

    always #5 i_clock = ~i_clock;

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic clear_inputs();
        i_start = 0; i_mode = 0; i_step = 0;
        i_idex_memread = 0; i_idex_rt = 0; i_ifid_rs = 0; i_ifid_rt = 0;
        i_halt_id = 0; i_mem_req = 0; i_mem_ack = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_reset = 0;
        tick();
        i_reset = 1;
        #1;
    endtask

    task automatic start_run(input logic mode);
        i_start = 1; i_mode = mode;
        tick();
        i_start = 0; i_mode = 0;
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_reset = 0;
        #3;
        n_checks++;
        if (o_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", o_state); end
        n_checks++;
        if (en_vec !== EN_OFF) begin n_fail++; $display("FAIL reset_enables: got %b expected %b", en_vec, EN_OFF); end
        n_checks++;
        if (o_cycles !== 32'd0 || o_halted !== 1'b0) begin
            n_fail++; $display("FAIL reset_cnt_halted: got cycles=%0d halted=%b expected 0/0", o_cycles, o_halted);
        end
        tick();
        i_reset = 1;
        tick();
        tick();
        n_checks++;
        if (o_state !== 3'd0 || en_vec !== EN_OFF) begin
            n_fail++; $display("FAIL idle_hold: got state=%0d en=%b expected 0/%b", o_state, en_vec, EN_OFF);
        end
    endtask

    task automatic test_run_clean();
        do_reset();
        start_run(1'b0);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (o_state !== 3'd1 || en_vec !== EN_CLEAN) begin
                n_fail++; $display("FAIL run_clean[%0d]: got state=%0d en=%b expected 1/%b", i, o_state, en_vec, EN_CLEAN);
            end
            tick();
        end
        n_checks++;
        if (o_cycles !== 32'd10) begin n_fail++; $display("FAIL run_cycles: got %0d expected 10", o_cycles); end
    endtask

    task automatic test_loaduse();
        // rs match stall
        i_idex_memread = 1; i_idex_rt = 5'd5; i_ifid_rs = 5'd5; i_ifid_rt = 5'd9;
        #1;
        n_checks++;
        if (en_vec !== EN_BUB) begin n_fail++; $display("FAIL loaduse_rs: got %b expected %b", en_vec, EN_BUB); end
        tick();
        n_checks++;
        if (o_cycles !== 32'd11) begin n_fail++; $display("FAIL loaduse_cycles: got %0d expected 11", o_cycles); end
        // rt = 0 never stalls
        i_idex_rt = 5'd0; i_ifid_rs = 5'd0; i_ifid_rt = 5'd0;
        #1;
        n_checks++;
        if (en_vec !== EN_CLEAN) begin n_fail++; $display("FAIL loaduse_r0: got %b expected %b", en_vec, EN_CLEAN); end
        tick();
        // rt match stall with halt present: halt ignored
        i_idex_rt = 5'd7; i_ifid_rs = 5'd3; i_ifid_rt = 5'd7; i_halt_id = 1;
        #1;
        n_checks++;
        if (en_vec !== EN_BUB) begin n_fail++; $display("FAIL loaduse_rt: got %b expected %b", en_vec, EN_BUB); end
        tick();
        n_checks++;
        if (o_state !== 3'd1 || o_cycles !== 32'd13) begin
            n_fail++; $display("FAIL loaduse_halt_ignored: got state=%0d cycles=%0d expected 1/13", o_state, o_cycles);
        end
        i_idex_memread = 0; i_idex_rt = 0; i_ifid_rs = 0; i_ifid_rt = 0; i_halt_id = 0;
        #1;
    endtask

    task automatic test_freeze();
        i_mem_req = 1; i_mem_ack = 0; i_halt_id = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (o_state !== 3'd1 || en_vec !== EN_OFF) begin
                n_fail++; $display("FAIL freeze[%0d]: got state=%0d en=%b expected 1/%b", i, o_state, en_vec, EN_OFF);
            end
            tick();
        end
        n_checks++;
        if (o_cycles !== 32'd13 || o_state !== 3'd1) begin
            n_fail++; $display("FAIL freeze_hold: got cycles=%0d state=%0d expected 13/1", o_cycles, o_state);
        end
        i_mem_ack = 1; i_halt_id = 0;
        #1;
        n_checks++;
        if (en_vec !== EN_CLEAN) begin n_fail++; $display("FAIL freeze_ack: got %b expected %b", en_vec, EN_CLEAN); end
        tick();
        i_mem_req = 0; i_mem_ack = 0;
        n_checks++;
        if (o_cycles !== 32'd14) begin n_fail++; $display("FAIL freeze_resume: got %0d expected 14", o_cycles); end
    endtask

    task automatic test_halt();
        i_halt_id = 1;
        #1;
        n_checks++;
        if (en_vec !== EN_CLEAN) begin n_fail++; $display("FAIL halt_issue: got %b expected %b", en_vec, EN_CLEAN); end
        tick();
        i_halt_id = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (o_state !== 3'd4 || en_vec !== EN_BUB) begin
                n_fail++; $display("FAIL drain[%0d]: got state=%0d en=%b expected 4/%b", i, o_state, en_vec, EN_BUB);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            i_start = 1;
            #1;
            n_checks++;
            if (o_state !== 3'd5 || o_halted !== 1'b1 || en_vec !== EN_OFF) begin
                n_fail++; $display("FAIL halted[%0d]: got state=%0d halted=%b en=%b expected 5/1/%b", i, o_state, o_halted, en_vec, EN_OFF);
            end
            tick();
        end
        i_start = 0;
        n_checks++;
        if (o_cycles !== 32'd18) begin n_fail++; $display("FAIL halt_cycles: got %0d expected 18", o_cycles); end
    endtask

    task automatic test_drain_freeze();
        do_reset();
        start_run(1'b0);
        i_halt_id = 1;
        tick();
        i_halt_id = 0;
        tick();                         // first drain cycle advances
        i_mem_req = 1; i_mem_ack = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (o_state !== 3'd4 || en_vec !== EN_OFF) begin
                n_fail++; $display("FAIL drain_freeze[%0d]: got state=%0d en=%b expected 4/%b", i, o_state, en_vec, EN_OFF);
            end
            tick();
        end
        i_mem_req = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (o_state !== 3'd4 || en_vec !== EN_BUB) begin
                n_fail++; $display("FAIL drain_rest[%0d]: got state=%0d en=%b expected 4/%b", i, o_state, en_vec, EN_BUB);
            end
            tick();
        end
        n_checks++;
        if (o_state !== 3'd5 || o_cycles !== 32'd4) begin
            n_fail++; $display("FAIL drain_ext_end: got state=%0d cycles=%0d expected 5/4", o_state, o_cycles);
        end
    endtask

    task automatic test_step();
        do_reset();
        start_run(1'b1);
        n_checks++;
        if (o_state !== 3'd2 || en_vec !== EN_OFF) begin
            n_fail++; $display("FAIL step_wait: got state=%0d en=%b expected 2/%b", o_state, en_vec, EN_OFF);
        end
        // held step gives exactly one advancing cycle
        i_step = 1;
        for (int i = 0; i < 5; i++) tick();
        i_step = 0;
        tick();
        n_checks++;
        if (o_state !== 3'd2 || o_cycles !== 32'd1) begin
            n_fail++; $display("FAIL step_hold: got state=%0d cycles=%0d expected 2/1", o_state, o_cycles);
        end
        // three pulses: plain, frozen-then-released, load-use bubble
        do_reset();
        start_run(1'b1);
        i_step = 1; tick(); i_step = 0;
        n_checks++;
        if (o_state !== 3'd3 || en_vec !== EN_CLEAN) begin
            n_fail++; $display("FAIL step_exec: got state=%0d en=%b expected 3/%b", o_state, en_vec, EN_CLEAN);
        end
        tick();
        i_step = 1; tick(); i_step = 0;
        i_mem_req = 1; i_mem_ack = 0;
        tick();
        tick();
        #1;
        n_checks++;
        if (o_state !== 3'd3 || en_vec !== EN_OFF || o_cycles !== 32'd1) begin
            n_fail++; $display("FAIL step_freeze: got state=%0d en=%b cycles=%0d expected 3/%b/1", o_state, en_vec, o_cycles, EN_OFF);
        end
        i_mem_req = 0;
        tick();
        i_step = 1; tick(); i_step = 0;
        i_idex_memread = 1; i_idex_rt = 5'd4; i_ifid_rs = 5'd4;
        #1;
        n_checks++;
        if (o_state !== 3'd3 || en_vec !== EN_BUB) begin
            n_fail++; $display("FAIL step_loaduse: got state=%0d en=%b expected 3/%b", o_state, en_vec, EN_BUB);
        end
        tick();
        i_idex_memread = 0; i_idex_rt = 0; i_ifid_rs = 0;
        n_checks++;
        if (o_state !== 3'd2 || o_cycles !== 32'd3) begin
            n_fail++; $display("FAIL step_pulses: got state=%0d cycles=%0d expected 2/3", o_state, o_cycles);
        end
        // step with HALT goes to drain
        i_step = 1; tick(); i_step = 0; i_halt_id = 1;
        tick();
        i_halt_id = 0;
        n_checks++;
        if (o_state !== 3'd4) begin n_fail++; $display("FAIL step_halt: got %0d expected 4", o_state); end
    endtask

    task automatic test_async_reset();
        do_reset();
        start_run(1'b0);
        i_halt_id = 1; tick(); i_halt_id = 0;
        tick();
        #2;
        i_reset = 0;
        #1;
        n_checks++;
        if (o_state !== 3'd0 || en_vec !== EN_OFF || o_cycles !== 32'd0 || o_halted !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got state=%0d en=%b cycles=%0d halted=%b expected 0/%b/0/0", o_state, en_vec, o_cycles, o_halted, EN_OFF);
        end
        #2;
        i_reset = 1;
        tick();
        tick();
        n_checks++;
        if (o_state !== 3'd0 || en_vec !== EN_OFF) begin
            n_fail++; $display("FAIL post_reset_idle: got state=%0d en=%b expected 0/%b", o_state, en_vec, EN_OFF);
        end
        start_run(1'b0);
        n_checks++;
        if (o_state !== 3'd1) begin n_fail++; $display("FAIL post_reset_start: got %0d expected 1", o_state); end
    endtask

    initial begin
        test_reset();
        test_run_clean();
        test_loaduse();
        test_freeze();
        test_halt();
        test_drain_freeze();
        test_step();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
